// File: rtl/head_table_ctrl_pkg.sv
// hash_table: shared widths, command/task types and the write-forwarding match helper
//   BUCKET_WIDTH / HEAD_PTR_WIDTH size the head RAM; ht_command_t is the hashed command,
//   ht_pdata_t the bucket-resolved task sent to the data table, head_ram_data_t one RAM word.
package hash_table;
  localparam int BUCKET_WIDTH = 4;
  localparam int HEAD_PTR_WIDTH = 8;
  localparam int KEY_WIDTH = 16;
  localparam int VALUE_WIDTH = 16;
  typedef enum logic [1:0] {OP_INIT, OP_SEARCH, OP_INSERT, OP_DELETE} ht_opcode_t;
  typedef struct packed {
    ht_opcode_t opcode;
    logic [KEY_WIDTH-1:0] key;
    logic [VALUE_WIDTH-1:0] value;
  } ht_command_t;
  typedef struct packed {
    logic [HEAD_PTR_WIDTH-1:0] ptr;
    logic ptr_val;
  } head_ram_data_t;
  typedef struct packed {
    ht_command_t cmd;
    logic [BUCKET_WIDTH-1:0] bucket;
    logic [HEAD_PTR_WIDTH-1:0] head_ptr;
    logic head_ptr_val;
  } ht_pdata_t;
  typedef struct packed {
    logic v;
    ht_command_t cmd;
    logic [BUCKET_WIDTH-1:0] bucket;
    logic fwd;
    head_ram_data_t fd;
  } ht_stage_t;
  function automatic logic fwd_hit(input logic wr_en, input logic [BUCKET_WIDTH-1:0] wr_addr,
                                   input logic [BUCKET_WIDTH-1:0] bucket);
    return wr_en && wr_addr == bucket;
  endfunction
endpackage

// File: rtl/head_table_if.sv
// head_table_if: head-pointer write bus from the init/insert/delete engines to the head table
//   wr_addr bucket, wr_data_ptr/wr_data_ptr_val new head, wr_en write strobe (always taken).
interface head_table_if;
  import hash_table::*;
  logic [BUCKET_WIDTH-1:0] wr_addr;
  logic [HEAD_PTR_WIDTH-1:0] wr_data_ptr;
  logic wr_data_ptr_val;
  logic wr_en;
  modport master(output wr_addr, wr_data_ptr, wr_data_ptr_val, wr_en);
  modport slave(input wr_addr, wr_data_ptr, wr_data_ptr_val, wr_en);
endinterface

// File: rtl/head_table_ctrl_fwd_fifo.sv
// head_fwd_fifo: output FIFO whose entries snoop head writes and replace their head fields on a bucket match
//   push_i/push_data_i enqueue; pop_i dequeues when non-empty; wr_en_i/wr_addr_i/wr_data_i snoop port;
//   data_o/valid_o present the oldest entry; count_o is the registered occupancy.
module head_fwd_fifo
  import hash_table::*;
#(
  parameter int DEPTH = 4
)(
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  ht_pdata_t push_data_i,
  input  logic pop_i,
  input  logic wr_en_i,
  input  logic [BUCKET_WIDTH-1:0] wr_addr_i,
  input  head_ram_data_t wr_data_i,
  output ht_pdata_t data_o,
  output logic valid_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  ht_pdata_t mem_q [DEPTH];
  ht_pdata_t mem_d [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic pop;
  assign valid_o = count_q != '0;
  assign pop = pop_i && valid_o;
  assign data_o = mem_q[rptr_q];
  assign count_o = count_q;
  // Free slots are snooped too; their contents are dead, so no occupancy gating is needed.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = push_i && wptr_q == AW'(i) ? push_data_i : mem_q[i];
      if (fwd_hit(wr_en_i, wr_addr_i, mem_d[i].bucket)) begin
        mem_d[i].head_ptr = wr_data_i.ptr;
        mem_d[i].head_ptr_val = wr_data_i.ptr_val;
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      mem_q <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wptr_q <= wptr_q + AW'(push_i);
      rptr_q <= rptr_q + AW'(pop);
      count_q <= count_q + CW'(push_i) - CW'(pop);
    end
endmodule

// File: rtl/true_dual_port_ram_single_clock.sv
// true_dual_port_ram_single_clock: single-clock RAM, port A read, port B write, old data on collision
//   clk_i clock; addr_a_i/q_a_o read port; we_b_i/addr_b_i/data_b_i write port.
//   REGISTER_OUT adds an output register (read latency 2 instead of 1). Contents are never reset.
module true_dual_port_ram_single_clock #(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 4,
  parameter int REGISTER_OUT = 1
)(
  input  logic clk_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  output logic [DATA_WIDTH-1:0] q_a_o,
  input  logic we_b_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  input  logic [DATA_WIDTH-1:0] data_b_i
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_q;
  always_ff @(posedge clk_i) begin
    if (we_b_i) mem_q[addr_b_i] <= data_b_i;
    rd_q <= mem_q[addr_a_i];
  end
  if (REGISTER_OUT != 0) begin : g_reg
    logic [DATA_WIDTH-1:0] out_q;
    always_ff @(posedge clk_i) out_q <= rd_q;
    assign q_a_o = out_q;
  end else begin : g_comb
    assign q_a_o = rd_q;
  end
endmodule

// File: rtl/head_table_ctrl.sv
// head_table_ctrl: looks up bucket head pointers and streams bucket-resolved tasks to the data table
//   clk_i/rst_i clock and async active-high reset; cmd_i/bucket_i/cmd_valid_i/cmd_ready_o command in;
//   pdata_o/pdata_valid_o/pdata_ready_i task stream out; head_table_if slave applies head-pointer writes.
module head_table_ctrl
  import hash_table::*;
#(
  parameter int RAM_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
)(
  input  logic clk_i,
  input  logic rst_i,
  input  ht_command_t cmd_i,
  input  logic [BUCKET_WIDTH-1:0] bucket_i,
  input  logic cmd_valid_i,
  output logic cmd_ready_o,
  output ht_pdata_t pdata_o,
  output logic pdata_valid_o,
  input  logic pdata_ready_i,
  head_table_if.slave head_table_if
);
  ht_stage_t stage_q [RAM_LATENCY];
  ht_stage_t stage_d [RAM_LATENCY];
  ht_stage_t exit_s;
  head_ram_data_t wr_data, ram_q;
  ht_pdata_t push_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [31:0] in_flight;
  logic accept;
  assign wr_data = '{ptr: head_table_if.wr_data_ptr, ptr_val: head_table_if.wr_data_ptr_val};
  assign accept = cmd_valid_i && cmd_ready_o;
  assign exit_s = stage_q[RAM_LATENCY-1];
  assign push_data = '{cmd: exit_s.cmd, bucket: exit_s.bucket,
                       head_ptr: exit_s.fwd ? exit_s.fd.ptr : ram_q.ptr,
                       head_ptr_val: exit_s.fwd ? exit_s.fd.ptr_val : ram_q.ptr_val};
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RAM_LATENCY; i++) in_flight = in_flight + 32'(stage_q[i].v);
  end
  // Credits cover pipeline plus FIFO, so an accepted command always finds a FIFO slot at exit.
  assign cmd_ready_o = 32'(fifo_count) + in_flight < 32'(FIFO_DEPTH);
  // A write in the issue cycle is caught on stage 0 because the RAM returns old data then.
  always_comb begin
    stage_d[0] = '{v: accept, cmd: cmd_i, bucket: bucket_i, fwd: 1'b0, fd: '0};
    for (int i = 1; i < RAM_LATENCY; i++) stage_d[i] = stage_q[i-1];
    for (int i = 0; i < RAM_LATENCY; i++)
      if (fwd_hit(head_table_if.wr_en, head_table_if.wr_addr, stage_d[i].bucket)) begin
        stage_d[i].fwd = 1'b1;
        stage_d[i].fd = wr_data;
      end
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) stage_q <= '{default: '0};
    else stage_q <= stage_d;
  true_dual_port_ram_single_clock #(
    .DATA_WIDTH($bits(head_ram_data_t)),
    .ADDR_WIDTH(BUCKET_WIDTH),
    .REGISTER_OUT(RAM_LATENCY > 1 ? 1 : 0)
  ) u_ram (
    .clk_i(clk_i),
    .addr_a_i(bucket_i),
    .q_a_o(ram_q),
    .we_b_i(head_table_if.wr_en),
    .addr_b_i(head_table_if.wr_addr),
    .data_b_i(wr_data)
  );
  // A write in the exit cycle is applied by the FIFO snoop on the entry being pushed.
  head_fwd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push_i(exit_s.v),
    .push_data_i(push_data),
    .pop_i(pdata_ready_i),
    .wr_en_i(head_table_if.wr_en),
    .wr_addr_i(head_table_if.wr_addr),
    .wr_data_i(wr_data),
    .data_o(pdata_o),
    .valid_o(pdata_valid_o),
    .count_o(fifo_count)
  );
endmodule
